led_pattern_monitor: RTL and testbench
======================================

// Module: led_pattern_monitor
// PURPOSE
//  Reader on the LED side of bound_flasher. Samples the 16-bit LED bus and the flick input
//  every clock and decodes the lamp pattern into a level and a direction.
//  Checks the pattern is legal: it must be a thermometer code that moves by at most one lamp per step.
//  Logs every turn-point (peak/valley, with a kickback tag) in a small first-word-fall-through FIFO.
//  Sits beside bound_flasher in the top level and in benches, as a self-checking observer.
// PARAMETERS
//  WIDTH     16  number of lamps on the LED bus
//  MAX_STEP  1   largest legal change in level between consecutive samples
//  TP_DEPTH  8   depth of the turn-point FIFO (power of 2)
//  LW        5   level width, equal to $clog2(WIDTH+1)
// PORTS
//  clk         in   1       system clock, rising edge
//  rst         in   1       synchronous reset, active-high
//  led         in   WIDTH   LED bus driven by the flasher
//  flick       in   1       same flick signal that the flasher sees
//  level       out  LW      decoded lamp count, 0..WIDTH
//  dir         out  2       00 idle, 01 up, 10 down
//  err         out  1       sticky error flag
//  err_code    out  2       first error seen: 00 none, 01 non-thermometer, 10 step > MAX_STEP
//  turn_pulse  out  1       1-cycle pulse on each direction reversal
//  seq_done    out  1       1-cycle pulse when level returns to 0 from DOWN
//  turn_cnt    out  8       count of reversals, saturates at 255
//  tp_rd_en    in   1       pop the FIFO head
//  tp_rd_data  out  LW+2    {kick, is_peak, level} of the FIFO head
//  tp_empty    out  1       FIFO empty
//  tp_full     out  1       FIFO full
//  tp_ovf      out  1       sticky flag: a turn-point was dropped because the FIFO was full
// BEHAVIOUR
//  Reset (rst=1 at a clk edge) forces:
//   - all outputs to 0 except tp_empty=1;
//   - FIFO emptied; FSM to IDLE; prev_valid=0.
//   Reset applied mid-sequence aborts it, and no seq_done pulse is issued.
//  Input stage: led and flick are registered into led_q and flick_q at every edge.
//  Decode: led_q is legal iff led_q == 2^k-1; then cur = k.
//   - Illegal led_q: set err. If err_code==00, set err_code=01.
//   - On an illegal sample, level and the FSM hold their values.
//  Step check: if prev_valid and |cur - level| > MAX_STEP:
//   - set err; if err_code==00, set err_code=10;
//   - the sample is still accepted and level is updated.
//  First legal sample after reset:
//   - loads level with no step check and sets prev_valid;
//   - FSM goes to UP if cur>0, else stays IDLE.
//  Latency: a change on led appears on level/dir/turn_pulse/seq_done 2 edges later.
//  FSM (dir output = state), driven by each legal sample:
//   IDLE: cur>level -> UP. Otherwise stay in IDLE.
//   UP:
//    - cur>level or cur==level -> stay in UP;
//    - cur<level -> DOWN, and record a turn-point {kick, 1, level} (level before the update).
//   DOWN:
//    - cur<level -> stay in DOWN; if cur==0, pulse seq_done and go to IDLE;
//    - cur==level -> stay in DOWN;
//    - cur>level -> UP, and record a turn-point {0, 0, level}.
//  kick = flick_q & (level < WIDTH). It is set only on peaks (a kickback before full brightness).
//  Turn event, in the same cycle:
//   - turn_pulse=1;
//   - turn_cnt increments, saturating at 255;
//   - the entry is pushed to the FIFO.
//  FIFO:
//   - tp_rd_data always shows the head. tp_rd_en when empty is ignored.
//   - Push while full with no pop: the entry is dropped and tp_ovf is set.
//   - Push and pop in the same cycle while full: both take effect, nothing is dropped.
//   - Push and pop in the same cycle while empty: the entry is stored and the pop is ignored.
//  err, err_code and tp_ovf clear only on rst. The FSM keeps tracking after an error.
// TESTING
//  T1 reset: drive led=16'h00FF, hold rst=1 for 2 cycles, then release ->
//     during reset all outputs are 0 and tp_empty=1; after release, level=8, dir=01, 2 edges later.
//  T2 full sweep: led 0->FFFF one bit per clk, then back to 0, flick=0 ->
//     one FIFO entry {0,1,16}; turn_cnt=1; seq_done pulses once, 2 clks after led=0; err=0.
//  T3 kickback: ramp to 16'h001F, then flick=1 while led goes to 16'h000F ->
//     FIFO entry {1,1,5}; turn_pulse is high for 1 cycle.
//  T4 illegal pattern: from level 3, drive led=16'h0005 ->
//     err=1, err_code=01; level stays 3; the FSM is unaffected.
//  T5 step error: led 16'h0003 -> 16'h003F ->
//     err=1, err_code=10, level=6. A later non-thermometer sample leaves err_code at 10.
//  T6 FIFO: 9 reversals with no reads ->
//     tp_full=1 after 8; the 9th entry is dropped and tp_ovf=1;
//     8 pops return the entries in order, then tp_empty=1;
//     also pop and push in the same cycle while full -> no drop.

Source files
------------

// File: rtl/led_pattern_monitor.sv
// Observer for the bound_flasher LED bus: decodes the thermometer lamp pattern into
// level/direction, flags illegal patterns and oversize steps, and logs turn-points in a FIFO.
module led_pattern_monitor #(
    parameter int WIDTH    = 16,
    parameter int MAX_STEP = 1,
    parameter int TP_DEPTH = 8,
    parameter int LW       = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] led,
    input  logic             flick,
    output logic [LW-1:0]    level,
    output logic [1:0]       dir,
    output logic             err,
    output logic [1:0]       err_code,
    output logic             turn_pulse,
    output logic             seq_done,
    output logic [7:0]       turn_cnt,
    input  logic             tp_rd_en,
    output logic [LW+1:0]    tp_rd_data,
    output logic             tp_empty,
    output logic             tp_full,
    output logic             tp_ovf
);

    localparam int AW = (TP_DEPTH > 1) ? $clog2(TP_DEPTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        UP   = 2'b01,
        DOWN = 2'b10
    } state_t;

    state_t            state, state_next;
    logic [WIDTH-1:0]  led_q;
    logic              flick_q;
    logic [WIDTH:0]    led_inc;
    logic              legal;
    logic [LW-1:0]     cur;
    logic [LW-1:0]     diff;
    logic              step_bad;
    logic              kick;
    logic [LW-1:0]     level_next;
    logic              turn;
    logic              seq_next;
    logic [LW+1:0]     tp_entry;
    logic              prev_valid;
    logic [LW+1:0]     mem [TP_DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [AW:0]       count;
    logic              push, pop;

    // Input stage is deliberately not reset so the first sample after reset is the live bus.
    always_ff @(posedge clk) begin
        led_q   <= led;
        flick_q <= flick;
    end

    // 2^k-1 is the only form where x & (x+1) is zero.
    assign led_inc = {1'b0, led_q} + {{WIDTH{1'b0}}, 1'b1};
    assign legal   = ((led_inc[WIDTH-1:0] & led_q) == '0);

    always_comb begin
        cur = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            cur = cur + LW'(led_q[i]);
        end
    end

    assign diff     = (cur > level) ? (cur - level) : (level - cur);
    assign step_bad = prev_valid && (diff > LW'(MAX_STEP));
    assign kick     = flick_q && (level < LW'(WIDTH));

    always_comb begin
        state_next = state;
        level_next = level;
        turn       = 1'b0;
        seq_next   = 1'b0;
        tp_entry   = '0;
        if (legal) begin
            level_next = cur;
            if (!prev_valid) begin
                state_next = (cur != '0) ? UP : IDLE;
            end else begin
                unique case (state)
                    IDLE: if (cur > level) state_next = UP;
                    UP: begin
                        if (cur < level) begin
                            state_next = DOWN;
                            turn       = 1'b1;
                            tp_entry   = {kick, 1'b1, level};
                        end
                    end
                    DOWN: begin
                        if (cur < level) begin
                            if (cur == '0) begin
                                seq_next   = 1'b1;
                                state_next = IDLE;
                            end
                        end else if (cur > level) begin
                            state_next = UP;
                            turn       = 1'b1;
                            tp_entry   = {1'b0, 1'b0, level};
                        end
                    end
                    default: state_next = IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    assign tp_empty = (count == '0);
    assign tp_full  = (count == (AW+1)'(TP_DEPTH));
    assign pop      = tp_rd_en && !tp_empty;
    assign push     = turn && (!tp_full || pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            level      <= '0;
            prev_valid <= 1'b0;
            err        <= 1'b0;
            err_code   <= 2'b00;
            turn_pulse <= 1'b0;
            seq_done   <= 1'b0;
            turn_cnt   <= '0;
            tp_ovf     <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
        end else begin
            level      <= level_next;
            turn_pulse <= turn;
            seq_done   <= seq_next;
            if (legal) prev_valid <= 1'b1;
            if (!legal) begin
                err <= 1'b1;
                if (err_code == 2'b00) err_code <= 2'b01;
            end else if (step_bad) begin
                err <= 1'b1;
                if (err_code == 2'b00) err_code <= 2'b10;
            end
            if (turn && turn_cnt != 8'hFF) turn_cnt <= turn_cnt + 8'd1;
            if (turn && !push) tp_ovf <= 1'b1;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (!push && pop) count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= tp_entry;
    end

    assign tp_rd_data = tp_empty ? '0 : mem[rd_ptr];
    assign dir        = state;

endmodule

// File: tb/tb_led_pattern_monitor.sv
// Directed self-checking bench for led_pattern_monitor; inputs change on the falling
// edge and outputs are sampled on the falling edge.
module tb_led_pattern_monitor;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] led;
    logic        flick;
    logic        tp_rd_en;
    logic [4:0]  level;
    logic [1:0]  dir;
    logic        err;
    logic [1:0]  err_code;
    logic        turn_pulse;
    logic        seq_done;
    logic [7:0]  turn_cnt;
    logic [6:0]  tp_rd_data;
    logic        tp_empty;
    logic        tp_full;
    logic        tp_ovf;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    led_pattern_monitor #(
        .WIDTH(16), .MAX_STEP(1), .TP_DEPTH(8), .LW(5)
    ) dut (
        .clk(clk), .rst(rst), .led(led), .flick(flick),
        .level(level), .dir(dir), .err(err), .err_code(err_code),
        .turn_pulse(turn_pulse), .seq_done(seq_done), .turn_cnt(turn_cnt),
        .tp_rd_en(tp_rd_en), .tp_rd_data(tp_rd_data), .tp_empty(tp_empty),
        .tp_full(tp_full), .tp_ovf(tp_ovf)
    );

    // Drive one sample and advance to the next falling edge.
    task automatic put(input logic [15:0] v, input logic f, input logic rd);
        led      = v;
        flick    = f;
        tp_rd_en = rd;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1; led = '0; flick = 1'b0; tp_rd_en = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    function automatic logic [15:0] therm(input int n);
        logic [16:0] t;
        t = (17'd1 << n) - 17'd1;
        return t[15:0];
    endfunction

    task automatic test_reset();
        logic [29:0] obs;
        rst = 1'b1; led = 16'h00FF; flick = 1'b0; tp_rd_en = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            obs = {level, dir, err, err_code, turn_pulse, seq_done, turn_cnt,
                   tp_rd_data, tp_empty, tp_full, tp_ovf};
            checks++;
            if (obs !== 30'h4) begin
                errors++;
                $display("FAIL reset_outputs cycle %0d: got %h expected %h", i, obs, 30'h4);
            end
        end
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (level !== 5'd8) begin errors++; $display("FAIL reset_release_level: got %0d expected 8", level); end
        checks++;
        if (dir !== 2'b01) begin errors++; $display("FAIL reset_release_dir: got %b expected 01", dir); end
        checks++;
        if (err !== 1'b0) begin errors++; $display("FAIL reset_release_err: got %b expected 0", err); end
    endtask

    task automatic test_sweep();
        int n, turns, turn_at, seqs, seq_at;
        turns = 0; seqs = 0; turn_at = -1; seq_at = -1;
        do_reset();
        for (int idx = 0; idx < 36; idx++) begin
            n = (idx < 16) ? idx + 1 : ((idx < 32) ? 31 - idx : 0);
            put(therm(n), 1'b0, 1'b0);
            if (turn_pulse === 1'b1) begin turns++; turn_at = idx; end
            if (seq_done === 1'b1) begin seqs++; seq_at = idx; end
        end
        checks++;
        if (turns !== 1) begin errors++; $display("FAIL sweep_turns: got %0d expected 1", turns); end
        checks++;
        if (turn_at !== 17) begin errors++; $display("FAIL sweep_turn_time: got %0d expected 17", turn_at); end
        checks++;
        if (seqs !== 1) begin errors++; $display("FAIL sweep_seq_done_count: got %0d expected 1", seqs); end
        checks++;
        if (seq_at !== 32) begin errors++; $display("FAIL sweep_seq_done_time: got %0d expected 32", seq_at); end
        checks++;
        if (tp_rd_data !== 7'h30) begin errors++; $display("FAIL sweep_fifo_head: got %h expected 30", tp_rd_data); end
        checks++;
        if (tp_empty !== 1'b0) begin errors++; $display("FAIL sweep_fifo_empty: got %b expected 0", tp_empty); end
        checks++;
        if (turn_cnt !== 8'd1) begin errors++; $display("FAIL sweep_turn_cnt: got %0d expected 1", turn_cnt); end
        checks++;
        if (err !== 1'b0) begin errors++; $display("FAIL sweep_err: got %b expected 0", err); end
        checks++;
        if ({level, dir} !== 7'd0) begin errors++; $display("FAIL sweep_final_idle: got %h expected 0", {level, dir}); end
    endtask

    task automatic test_kickback();
        do_reset();
        for (int n = 1; n <= 5; n++) put(therm(n), 1'b0, 1'b0);
        put(16'h000F, 1'b1, 1'b0);
        put(16'h000F, 1'b0, 1'b0);
        checks++;
        if (turn_pulse !== 1'b1) begin errors++; $display("FAIL kick_turn_pulse_high: got %b expected 1", turn_pulse); end
        checks++;
        if (tp_rd_data !== 7'h65) begin errors++; $display("FAIL kick_fifo_entry: got %h expected 65", tp_rd_data); end
        checks++;
        if (dir !== 2'b10) begin errors++; $display("FAIL kick_dir: got %b expected 10", dir); end
        put(16'h000F, 1'b0, 1'b0);
        checks++;
        if (turn_pulse !== 1'b0) begin errors++; $display("FAIL kick_turn_pulse_low: got %b expected 0", turn_pulse); end
        checks++;
        if (turn_cnt !== 8'd1) begin errors++; $display("FAIL kick_turn_cnt: got %0d expected 1", turn_cnt); end
    endtask

    task automatic test_illegal();
        do_reset();
        put(16'h0001, 1'b0, 1'b0);
        put(16'h0003, 1'b0, 1'b0);
        put(16'h0007, 1'b0, 1'b0);
        put(16'h0005, 1'b0, 1'b0);
        put(16'h0005, 1'b0, 1'b0);
        checks++;
        if ({err, err_code} !== 3'b101) begin errors++; $display("FAIL illegal_err: got %b expected 101", {err, err_code}); end
        checks++;
        if (level !== 5'd3) begin errors++; $display("FAIL illegal_level_hold: got %0d expected 3", level); end
        checks++;
        if (dir !== 2'b01) begin errors++; $display("FAIL illegal_dir_hold: got %b expected 01", dir); end
        put(16'h000F, 1'b0, 1'b0);
        put(16'h000F, 1'b0, 1'b0);
        checks++;
        if (level !== 5'd4) begin errors++; $display("FAIL illegal_resume_level: got %0d expected 4", level); end
        checks++;
        if ({dir, err, err_code} !== 5'b01101) begin errors++; $display("FAIL illegal_resume_state: got %b expected 01101", {dir, err, err_code}); end
    endtask

    task automatic test_step();
        do_reset();
        put(16'h0001, 1'b0, 1'b0);
        put(16'h0003, 1'b0, 1'b0);
        put(16'h003F, 1'b0, 1'b0);
        put(16'h003F, 1'b0, 1'b0);
        checks++;
        if ({err, err_code} !== 3'b110) begin errors++; $display("FAIL step_err: got %b expected 110", {err, err_code}); end
        checks++;
        if (level !== 5'd6) begin errors++; $display("FAIL step_level: got %0d expected 6", level); end
        put(16'h0005, 1'b0, 1'b0);
        put(16'h0005, 1'b0, 1'b0);
        checks++;
        if ({err, err_code} !== 3'b110) begin errors++; $display("FAIL step_code_sticky: got %b expected 110", {err, err_code}); end
        checks++;
        if ({level, dir} !== {5'd6, 2'b01}) begin errors++; $display("FAIL step_hold: got %h expected %h", {level, dir}, {5'd6, 2'b01}); end
    endtask

    // Alternating 1/3 gives a reversal on every sample from the third onward.
    task automatic test_fifo_overflow();
        logic [6:0] exp_e;
        do_reset();
        for (int idx = 0; idx <= 10; idx++) put((idx % 2 == 0) ? 16'h0001 : 16'h0003, 1'b0, 1'b0);
        checks++;
        if ({tp_full, tp_ovf} !== 2'b10) begin errors++; $display("FAIL ovf_full_after_8: got %b expected 10", {tp_full, tp_ovf}); end
        put(16'h0001, 1'b0, 1'b0);
        checks++;
        if ({tp_full, tp_ovf} !== 2'b11) begin errors++; $display("FAIL ovf_drop_9th: got %b expected 11", {tp_full, tp_ovf}); end
        checks++;
        if (turn_cnt !== 8'd9) begin errors++; $display("FAIL ovf_turn_cnt: got %0d expected 9", turn_cnt); end
        put(16'h0001, 1'b0, 1'b0);
        for (int k = 0; k < 8; k++) begin
            exp_e = (k % 2 == 0) ? 7'h22 : 7'h01;
            checks++;
            if (tp_rd_data !== exp_e) begin errors++; $display("FAIL ovf_pop_%0d: got %h expected %h", k, tp_rd_data, exp_e); end
            put(16'h0001, 1'b0, 1'b1);
        end
        checks++;
        if ({tp_empty, tp_full} !== 2'b10) begin errors++; $display("FAIL ovf_drained: got %b expected 10", {tp_empty, tp_full}); end
        put(16'h0001, 1'b0, 1'b1);
        checks++;
        if ({tp_empty, tp_rd_data, tp_ovf} !== {1'b1, 7'h00, 1'b1}) begin
            errors++; $display("FAIL ovf_pop_empty: got %h expected %h", {tp_empty, tp_rd_data, tp_ovf}, {1'b1, 7'h00, 1'b1});
        end
    endtask

    task automatic test_back_to_back();
        logic [6:0] exp_e;
        do_reset();
        for (int idx = 0; idx <= 10; idx++) put((idx % 2 == 0) ? 16'h0001 : 16'h0003, 1'b0, 1'b0);
        put(16'h0001, 1'b0, 1'b1);
        tp_rd_en = 1'b0;
        checks++;
        if ({tp_full, tp_ovf} !== 2'b10) begin errors++; $display("FAIL b2b_full_no_drop: got %b expected 10", {tp_full, tp_ovf}); end
        checks++;
        if (turn_cnt !== 8'd9) begin errors++; $display("FAIL b2b_turn_cnt: got %0d expected 9", turn_cnt); end
        for (int k = 0; k < 8; k++) begin
            exp_e = (k % 2 == 0) ? 7'h01 : 7'h22;
            checks++;
            if (tp_rd_data !== exp_e) begin errors++; $display("FAIL b2b_pop_%0d: got %h expected %h", k, tp_rd_data, exp_e); end
            put(16'h0001, 1'b0, 1'b1);
        end
        checks++;
        if (tp_empty !== 1'b1) begin errors++; $display("FAIL b2b_drained: got %b expected 1", tp_empty); end
        put(16'h0003, 1'b0, 1'b0);
        put(16'h0003, 1'b0, 1'b1);
        tp_rd_en = 1'b0;
        checks++;
        if ({tp_empty, tp_rd_data} !== {1'b0, 7'h01}) begin
            errors++; $display("FAIL b2b_push_pop_empty: got %h expected %h", {tp_empty, tp_rd_data}, {1'b0, 7'h01});
        end
    endtask

    task automatic test_abort();
        int seqs;
        seqs = 0;
        do_reset();
        put(16'h0001, 1'b0, 1'b0);
        put(16'h0003, 1'b0, 1'b0);
        put(16'h0007, 1'b0, 1'b0);
        put(16'h0003, 1'b0, 1'b0);
        put(16'h0001, 1'b0, 1'b0);
        rst = 1'b1; led = '0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            if (seq_done === 1'b1) seqs++;
        end
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (seq_done === 1'b1) seqs++;
        end
        checks++;
        if (seqs !== 0) begin errors++; $display("FAIL abort_no_seq_done: got %0d expected 0", seqs); end
        checks++;
        if ({level, dir, turn_cnt} !== 15'd0) begin errors++; $display("FAIL abort_idle: got %h expected 0", {level, dir, turn_cnt}); end
    endtask

    initial begin
        test_reset();
        test_sweep();
        test_kickback();
        test_illegal();
        test_step();
        test_fifo_overflow();
        test_back_to_back();
        test_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
